pc_round_engine: RTL and testbench

//  Iterative, parametrised constant-addition engine for the ASCON permutation datapath.
//  - Accepts a 320-bit state (t_state_array) over a valid/ready handshake.
//  - Runs p^a or p^b round scheduling; each round XORs C_LUT_ADDITION[r] into one lane.
//  - Processes ROUNDS_PER_CYCLE rounds per clock.
//  - Used as the round-counter/scheduler skeleton for the sequential permutation, and as a standalone pc-layer checker.

---
 rtl/pc_round_engine.sv | 167 ++++++++++++++++
 tb/tb_pc_round_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_round_engine.sv
// Iterative ASCON constant-addition (pc layer) engine with p^a / p^b round scheduling.
// Optional debug ports o_round / o_const are built when ASCON_PC_DEBUG_EN is defined.

package pc_round_pkg;
   localparam int NUM_LANES = 5;
   localparam int LANE_W    = 64;

   typedef logic [NUM_LANES-1:0][LANE_W-1:0] t_state_array;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} t_fsm;

   function automatic logic [7:0] c_lut_addition(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'hf0;
         4'd1:    return 8'he1;
         4'd2:    return 8'hd2;
         4'd3:    return 8'hc3;
         4'd4:    return 8'hb4;
         4'd5:    return 8'ha5;
         4'd6:    return 8'h96;
         4'd7:    return 8'h87;
         4'd8:    return 8'h78;
         4'd9:    return 8'h69;
         4'd10:   return 8'h5a;
         4'd11:   return 8'h4b;
         default: return 8'h00;
      endcase
   endfunction
endpackage

// One state lane; only the target lane folds the round constant into its low byte.
module pc_lane #(
   parameter int LANE_W    = 64,
   parameter bit IS_TARGET = 1'b0
) (
   input  logic [LANE_W-1:0] lane_in,
   input  logic [7:0]        rc,
   output logic [LANE_W-1:0] lane_out
);
   logic [7:0] rc_m;

   assign rc_m     = IS_TARGET ? rc : 8'h00;
   assign lane_out = lane_in ^ {{(LANE_W-8){1'b0}}, rc_m};
endmodule

module pc_round_engine
   import pc_round_pkg::*;
#(
   parameter int ROUNDS_A         = 12,
   parameter int ROUNDS_B         = 6,
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int TARGET_LANE      = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic         i_mode,
   input  t_state_array i_state,
   output logic         o_valid,
   input  logic         i_ready,
   output t_state_array o_state,
   output logic         o_busy
`ifdef ASCON_PC_DEBUG_EN
   ,
   output logic [3:0]   o_round,
   output logic [7:0]   o_const
`endif
);
   localparam int         K       = ROUNDS_PER_CYCLE;
   localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
   localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);
   localparam logic [3:0] STEP    = 4'(K);
   localparam logic [3:0] LAST    = 4'd12;

   if (ROUNDS_A < 1 || ROUNDS_A > 12 || ROUNDS_B < 1 || ROUNDS_B > ROUNDS_A ||
       K < 1 || (ROUNDS_A % K) != 0 || (ROUNDS_B % K) != 0 ||
       TARGET_LANE < 0 || TARGET_LANE >= NUM_LANES) begin : g_param_chk
      $fatal(1, "pc_round_engine: illegal parameter combination");
   end

   t_fsm         st_q;
   t_state_array state_q;
   t_state_array state_nxt;
   logic [3:0]   round_q;
   logic [3:0]   round_nxt;
   logic [7:0]   rc_comb;
   logic         ready_q;

   // K consecutive constants collapse to one XOR; r+k stays <= 11 because N is a multiple of K.
   always_comb begin
      rc_comb = 8'h00;
      if (st_q == ST_RUN) begin
         for (int k = 0; k < K; k++) begin
            rc_comb = rc_comb ^ c_lut_addition(round_q + 4'(k));
         end
      end
   end

   assign round_nxt = round_q + STEP;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      pc_lane #(
         .LANE_W   (LANE_W),
         .IS_TARGET(l == TARGET_LANE)
      ) u_lane (
         .lane_in (state_q[l]),
         .rc      (rc_comb),
         .lane_out(state_nxt[l])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         st_q    <= ST_IDLE;
         state_q <= '0;
         round_q <= '0;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
         o_state <= '0;
         ready_q <= 1'b1;
      end else begin
         case (st_q)
            ST_IDLE: begin
               if (i_valid) begin
                  state_q <= i_state;
                  round_q <= i_mode ? START_B : START_A;
                  st_q    <= ST_RUN;
                  o_busy  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            ST_RUN: begin
               state_q <= state_nxt;
               round_q <= round_nxt;
               if (round_nxt == LAST) begin
                  st_q    <= ST_DONE;
                  o_state <= state_nxt;
                  o_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               // Ready comes back one cycle after the result is taken, never in the same cycle.
               if (i_ready) begin
                  st_q    <= ST_IDLE;
                  o_valid <= 1'b0;
                  o_busy  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: st_q <= ST_IDLE;
         endcase
      end
   end

   assign o_ready = ready_q & ~i_rst;

`ifdef ASCON_PC_DEBUG_EN
   assign o_round = (st_q == ST_RUN) ? round_q : 4'd0;
   assign o_const = rc_comb;
`endif

   a_round_max: assert property (@(posedge i_clk) disable iff (i_rst) round_q <= LAST);
   a_hold_result: assert property (@(posedge i_clk) disable iff (i_rst)
      (o_valid && !i_ready) |=> (o_valid && $stable(o_state)));
   a_ready_idle: assert property (@(posedge i_clk) disable iff (i_rst)
      o_ready |-> (st_q == ST_IDLE));
endmodule

// File: tb/tb_pc_round_engine.sv
// Directed bench for pc_round_engine: default build (K=1) plus a K=3 instance.
module tb_pc_round_engine;
   import pc_round_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_valid, i_mode, i_ready;
   t_state_array i_state;
   logic         o_ready, o_valid, o_busy;
   t_state_array o_state;
   logic         v3, ir3, o_ready3, o_valid3, o_busy3;
   t_state_array o_state3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_round_engine dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
      .i_state(i_state), .o_valid(o_valid), .i_ready(i_ready), .o_state(o_state), .o_busy(o_busy)
   );

   pc_round_engine #(.ROUNDS_PER_CYCLE(3)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_valid(v3), .o_ready(o_ready3), .i_mode(i_mode),
      .i_state(i_state), .o_valid(o_valid3), .i_ready(ir3), .o_state(o_state3), .o_busy(o_busy3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one state to dut, counts edges from the handshake edge until o_valid (bounded).
   task automatic run(input logic mode, input t_state_array st, output int edges);
      i_mode  = mode;
      i_state = st;
      i_valid = 1'b1;
      tick();
      edges   = 1;
      i_valid = 1'b0;
      while (!o_valid && edges < 40) begin
         tick();
         edges++;
      end
   endtask

   task automatic run3(input logic mode, input t_state_array st, output int edges);
      i_mode  = mode;
      i_state = st;
      v3      = 1'b1;
      tick();
      edges   = 1;
      v3      = 1'b0;
      while (!o_valid3 && edges < 40) begin
         tick();
         edges++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; i_valid = 1'b1; i_mode = 1'b0; i_ready = 1'b0; v3 = 1'b0; ir3 = 1'b0;
      i_state = '1;
      tick(); tick();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      checks++; if (o_state !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", o_state); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", o_ready); end
      i_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", o_ready); end
      checks++; if (o_ready3 !== 1'b1 || o_busy3 !== 1'b0) begin
         errors++; $display("FAIL reset_k3_idle: got ready=%b busy=%b want 1 0", o_ready3, o_busy3); end
   endtask

   task automatic test_pa_zero();
      int e;
      run(1'b0, '0, e);
      checks++; if (e !== 13) begin errors++; $display("FAIL pa_latency: got %0d want 13", e); end
      checks++; if (o_state !== '0) begin errors++; $display("FAIL pa_zero_state: got %h want 0", o_state); end
      checks++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
         errors++; $display("FAIL pa_done_flags: got busy=%b ready=%b want 1 0", o_busy, o_ready); end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
         errors++; $display("FAIL pa_release: got v=%b busy=%b ready=%b want 0 0 1", o_valid, o_busy, o_ready); end
   endtask

   task automatic test_pb_zero();
      int e;
      t_state_array exp;
      exp = '0;
      exp[2] = 64'h11;
      run(1'b1, '0, e);
      checks++; if (e !== 7) begin errors++; $display("FAIL pb_latency: got %0d want 7", e); end
      checks++; if (o_state !== exp) begin errors++; $display("FAIL pb_zero_state: got %h want %h", o_state, exp); end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
   endtask

   task automatic test_pa_ones();
      int e;
      t_state_array st;
      st = '1;
      run(1'b0, st, e);
      checks++; if (o_state !== st) begin errors++; $display("FAIL pa_ones_state: got %h want %h", o_state, st); end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
   endtask

   // i_ready held high throughout: must not disturb RUN; only the target lane changes.
   task automatic test_pb_pattern();
      int e;
      t_state_array st, exp;
      st[0] = 64'hA5A5_A5A5_A5A5_A5A5;
      st[1] = 64'h5A5A_5A5A_5A5A_5A5A;
      st[2] = 64'h0123_4567_89AB_CDEF;
      st[3] = 64'hDEAD_BEEF_CAFE_F00D;
      st[4] = 64'hFFFF_FFFF_FFFF_FFFF;
      exp = st;
      exp[2] = 64'h0123_4567_89AB_CDFE;
      i_ready = 1'b1;
      run(1'b1, st, e);
      checks++; if (e !== 7) begin errors++; $display("FAIL pattern_latency: got %0d want 7", e); end
      checks++; if (o_state !== exp) begin errors++; $display("FAIL pattern_state: got %h want %h", o_state, exp); end
      tick();
      i_ready = 1'b0;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL pattern_consumed: got %b want 0", o_valid); end
   endtask

   task automatic test_backpressure();
      int e;
      t_state_array exp;
      exp = '0;
      exp[2] = 64'h11;
      run(1'b1, '0, e);
      i_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (o_valid !== 1'b1 || o_state !== exp || o_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d: got v=%b rdy=%b st=%h want 1 0 %h", i, o_valid, o_ready, o_state, exp); end
      end
      i_ready = 1'b1;
      tick();
      checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
         errors++; $display("FAIL bp_no_same_cycle_accept: got busy=%b rdy=%b v=%b want 0 1 0", o_busy, o_ready, o_valid); end
      tick();
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got %b want 1", o_busy); end
      i_valid = 1'b0;
      for (int i = 0; i < 40 && !o_valid; i++) tick();
      tick();
      i_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n;
      i_mode = 1'b1; i_state = '0; i_valid = 1'b1; i_ready = 1'b1;
      tick();
      n = 0;
      while (o_busy && n < 40) begin
         tick();
         n++;
      end
      tick();
      checks++; if (o_busy !== 1'b1 || n + 1 !== 8) begin
         errors++; $display("FAIL b2b_period: got %0d busy=%b want 8 1", n + 1, o_busy); end
      i_valid = 1'b0;
      for (int i = 0; i < 40 && !o_valid; i++) tick();
      tick();
      i_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int e;
      t_state_array exp;
      exp = '0;
      exp[2] = 64'h11;
      i_mode = 1'b0; i_state = '1; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      i_valid = 1'b1;
      tick();
      checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
         errors++; $display("FAIL rst_mid_abort: got busy=%b v=%b want 0 0", o_busy, o_valid); end
      tick();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_wins_handshake: got %b want 0", o_busy); end
      i_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", o_ready); end
      run(1'b1, '0, e);
      checks++; if (e !== 7 || o_state !== exp) begin
         errors++; $display("FAIL rst_fresh_pb: got %0d %h want 7 %h", e, o_state, exp); end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
   endtask

   task automatic test_k3();
      int e;
      t_state_array exp;
      run3(1'b0, '0, e);
      checks++; if (e !== 5) begin errors++; $display("FAIL k3_pa_latency: got %0d want 5", e); end
      checks++; if (o_state3 !== '0) begin errors++; $display("FAIL k3_pa_state: got %h want 0", o_state3); end
      ir3 = 1'b1;
      tick();
      ir3 = 1'b0;
      exp = '0;
      exp[2] = 64'h11;
      run3(1'b1, '0, e);
      checks++; if (e !== 3) begin errors++; $display("FAIL k3_pb_latency: got %0d want 3", e); end
      checks++; if (o_state3 !== exp) begin errors++; $display("FAIL k3_pb_state: got %h want %h", o_state3, exp); end
      ir3 = 1'b1;
      tick();
      ir3 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pa_zero();
      test_pb_zero();
      test_pa_ones();
      test_pb_pattern();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_k3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
